// File: rtl/xt_bus_pkg.sv
// Shared types and constants for the XT bus command generator and its neighbours
// (bus arbiter reuses the status decode and cycle types).
package xt_bus_pkg;

  // 8088 T-state sequence tracked by the command generator
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_TW   = 3'd4,
    ST_T4   = 3'd5
  } bus_state_t;

  // Encoding matches the raw S2..S0 status so a cast is a valid decode
  typedef enum logic [2:0] {
    CYC_INTA    = 3'b000,
    CYC_IOR     = 3'b001,
    CYC_IOW     = 3'b010,
    CYC_HALT    = 3'b011,
    CYC_FETCH   = 3'b100,
    CYC_MEMR    = 3'b101,
    CYC_MEMW    = 3'b110,
    CYC_PASSIVE = 3'b111
  } cycle_type_t;

  localparam logic [2:0] STATUS_PASSIVE = 3'b111;
  localparam logic [2:0] STATUS_HALT    = 3'b011;

endpackage

// File: rtl/xt_bus_status_decode.sv
// Combinational S2..S0 decode: cycle type plus data-direction class.
module xt_bus_status_decode
  import xt_bus_pkg::*;
(
  input  logic [2:0]  status_i,
  output cycle_type_t cycle_type_o,
  output logic        is_read_o,
  output logic        is_write_o
);

  // is_read covers every cycle where the CPU receives data (INTA and fetch included)
  always_comb begin
    cycle_type_o = cycle_type_t'(status_i);
    is_read_o    = (cycle_type_o inside {CYC_INTA, CYC_IOR, CYC_FETCH, CYC_MEMR});
    is_write_o   = (cycle_type_o inside {CYC_IOW, CYC_MEMW});
  end

endmodule

// File: rtl/xt_bus_controller.sv
// 8288-style bus command generator: S2..S0 -> T-states, ALE, command strobes,
// DT/R, DEN, wait-state insertion and DMA (AEN) strobe release.
// Optional macro XT_BUS_ADVANCED_WRITE_EN: write strobes assert at T2 instead of T3.
module xt_bus_controller
  import xt_bus_pkg::*;
#(
  parameter int unsigned CMD_DELAY_T  = 1,
  parameter int unsigned WAIT_TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_clock_en,
  input  logic [2:0] processor_status,
  input  logic       processor_ready,
  input  logic       address_enable_n,
  output logic       address_latch_enable,
  output logic       memory_read_n,
  output logic       memory_write_n,
  output logic       io_read_n,
  output logic       io_write_n,
  output logic       interrupt_acknowledge_n,
  output logic       data_transmit_receive_n,
  output logic       data_enable,
  output logic       halt_detected,
  output logic       no_command_state,
  output logic       wait_timeout
);

  localparam int unsigned DLY_W  = $clog2(CMD_DELAY_T + 2);
  localparam int unsigned WCNT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [DLY_W-1:0]  DLY_TARGET = DLY_W'(CMD_DELAY_T);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_TIMEOUT);
  localparam bit TIMEOUT_EN = (WAIT_TIMEOUT != 0);

  bus_state_t        state_q, state_d;
  cycle_type_t       cycle_q, cyc_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              armed_q, armed_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;

  logic ale_q, ale_d;
  logic memr_n_q, memr_n_d;
  logic memw_n_q, memw_n_d;
  logic ior_n_q, ior_n_d;
  logic iow_n_q, iow_n_d;
  logic inta_n_q, inta_n_d;
  logic dtr_n_q, dtr_n_d;
  logic den_q, den_d;
  logic halt_q, halt_d;
  logic nocmd_q, nocmd_d;
  logic wto_q, wto_d;

  cycle_type_t dec_type;
  logic        dec_read;
  logic        dec_write;
  logic        can_start;
  logic        start_cycle;
  logic        halt_hit;
  logic        timeout_hit;
  logic        in_cycle;
  logic        rd_on;
  logic        wr_on;

  xt_bus_status_decode u_decode (
    .status_i     (processor_status),
    .cycle_type_o (dec_type),
    .is_read_o    (dec_read),
    .is_write_o   (dec_write)
  );

  assign can_start = (processor_status != STATUS_PASSIVE) && (processor_status != STATUS_HALT);

  // Next-state logic; every T-state advance is qualified by cpu_clock_en.
  // After reset a passive status must be seen before the first cycle starts,
  // so a status left over from before reset cannot launch a spurious cycle.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    armed_d     = armed_q | (cpu_clock_en && (processor_status == STATUS_PASSIVE));
    start_cycle = 1'b0;
    halt_hit    = 1'b0;
    timeout_hit = 1'b0;
    if (cpu_clock_en) begin
      case (state_q)
        ST_IDLE: begin
          if (armed_q && can_start) begin
            state_d     = ST_T1;
            start_cycle = 1'b1;
          end else if (processor_status == STATUS_HALT) begin
            halt_hit = 1'b1;
          end
        end
        ST_T1: state_d = ST_T2;
        ST_T2: state_d = ST_T3;
        ST_T3: begin
          if (processor_ready) begin
            state_d = ST_T4;
          end else begin
            state_d    = ST_TW;
            wait_cnt_d = WCNT_W'(1);
          end
        end
        ST_TW: begin
          if (processor_ready) begin
            state_d = ST_T4;
          end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LIMIT)) begin
            state_d     = ST_T4;
            timeout_hit = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          end
        end
        ST_T4: begin
          if (can_start) begin
            state_d     = ST_T1;
            start_cycle = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            halt_hit = (processor_status == STATUS_HALT);
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // Clocks elapsed since T1, saturating; gates the read/INTA command delay
      if (start_cycle) begin
        dly_cnt_d = '0;
      end else if ((state_q != ST_IDLE) && (dly_cnt_q != '1)) begin
        dly_cnt_d = dly_cnt_q + DLY_W'(1);
      end
    end
  end

  // Output values for the state being entered; they are registered below
  always_comb begin
    cyc_d    = start_cycle ? dec_type  : cycle_q;
    read_d   = start_cycle ? dec_read  : read_q;
    write_d  = start_cycle ? dec_write : write_q;
    in_cycle = (state_d inside {ST_T1, ST_T2, ST_T3, ST_TW});
    rd_on    = in_cycle && (dly_cnt_d >= DLY_TARGET) && read_d;
`ifdef XT_BUS_ADVANCED_WRITE_EN
    wr_on    = (state_d inside {ST_T2, ST_T3, ST_TW}) && write_d;
`else
    wr_on    = (state_d inside {ST_T3, ST_TW}) && write_d;
`endif
    ale_d    = (state_d == ST_T1);
    memr_n_d = ~(rd_on && (cyc_d inside {CYC_MEMR, CYC_FETCH}));
    ior_n_d  = ~(rd_on && (cyc_d == CYC_IOR));
    inta_n_d = ~(rd_on && (cyc_d == CYC_INTA));
    memw_n_d = ~(wr_on && (cyc_d == CYC_MEMW));
    iow_n_d  = ~(wr_on && (cyc_d == CYC_IOW));
    dtr_n_d  = ~(in_cycle && read_d);
    den_d    = (state_d inside {ST_T2, ST_T3, ST_TW});
    nocmd_d  = (state_d inside {ST_IDLE, ST_T1, ST_T4});
    halt_d   = halt_hit;
    if (timeout_hit) begin
      wto_d = 1'b1;
    end else if (start_cycle) begin
      wto_d = 1'b0;
    end else begin
      wto_d = wto_q;
    end
  end

  // Bus FSM state, cycle latch and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cycle_q    <= CYC_PASSIVE;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      armed_q    <= 1'b0;
      wait_cnt_q <= '0;
      dly_cnt_q  <= '0;
      ale_q      <= 1'b0;
      memr_n_q   <= 1'b1;
      memw_n_q   <= 1'b1;
      ior_n_q    <= 1'b1;
      iow_n_q    <= 1'b1;
      inta_n_q   <= 1'b1;
      dtr_n_q    <= 1'b1;
      den_q      <= 1'b0;
      halt_q     <= 1'b0;
      nocmd_q    <= 1'b1;
      wto_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cyc_d;
      read_q     <= read_d;
      write_q    <= write_d;
      armed_q    <= armed_d;
      wait_cnt_q <= wait_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      ale_q      <= ale_d;
      memr_n_q   <= memr_n_d;
      memw_n_q   <= memw_n_d;
      ior_n_q    <= ior_n_d;
      iow_n_q    <= iow_n_d;
      inta_n_q   <= inta_n_d;
      dtr_n_q    <= dtr_n_d;
      den_q      <= den_d;
      halt_q     <= halt_d;
      nocmd_q    <= nocmd_d;
      wto_q      <= wto_d;
    end
  end

  // DMA ownership releases the command strobes and DEN without waiting for a clock
  assign memory_read_n           = memr_n_q | ~address_enable_n;
  assign memory_write_n          = memw_n_q | ~address_enable_n;
  assign io_read_n               = ior_n_q  | ~address_enable_n;
  assign io_write_n              = iow_n_q  | ~address_enable_n;
  assign interrupt_acknowledge_n = inta_n_q | ~address_enable_n;
  assign data_enable             = den_q & address_enable_n;
  assign address_latch_enable    = ale_q;
  assign data_transmit_receive_n = dtr_n_q;
  assign halt_detected           = halt_q;
  assign no_command_state        = nocmd_q;
  assign wait_timeout            = wto_q;

endmodule

// File: tb/tb_xt_bus_controller.sv
// Scoreboard bench for xt_bus_controller: stimulus queues hand-computed output
// vectors, a negedge monitor pops and compares them.
// Vector bit order: ale | memr_n memw_n ior_n iow_n inta_n | dtr_n | den | halt | nocmd | wto
module tb_xt_bus_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_clock_en = 1'b0;
  logic [2:0] processor_status = 3'b101;
  logic       processor_ready = 1'b1;
  logic       address_enable_n = 1'b1;
  logic       address_latch_enable;
  logic       memory_read_n;
  logic       memory_write_n;
  logic       io_read_n;
  logic       io_write_n;
  logic       interrupt_acknowledge_n;
  logic       data_transmit_receive_n;
  logic       data_enable;
  logic       halt_detected;
  logic       no_command_state;
  logic       wait_timeout;

  xt_bus_controller #(.CMD_DELAY_T(1), .WAIT_TIMEOUT(4)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .cpu_clock_en            (cpu_clock_en),
    .processor_status        (processor_status),
    .processor_ready         (processor_ready),
    .address_enable_n        (address_enable_n),
    .address_latch_enable    (address_latch_enable),
    .memory_read_n           (memory_read_n),
    .memory_write_n          (memory_write_n),
    .io_read_n               (io_read_n),
    .io_write_n              (io_write_n),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .data_transmit_receive_n (data_transmit_receive_n),
    .data_enable             (data_enable),
    .halt_detected           (halt_detected),
    .no_command_state        (no_command_state),
    .wait_timeout            (wait_timeout)
  );

  always #5 clock = ~clock;

`ifdef XT_BUS_ADVANCED_WRITE_EN
  localparam logic WR_T2 = 1'b0;
`else
  localparam logic WR_T2 = 1'b1;
`endif

  localparam logic [10:0] V_IDLE   = 11'b0_11111_1_0_0_1_0;
  localparam logic [10:0] V_HALT   = 11'b0_11111_1_0_1_1_0;
  localparam logic [10:0] V_T1_RD  = 11'b1_11111_0_0_0_1_0;
  localparam logic [10:0] V_T1_WR  = 11'b1_11111_1_0_0_1_0;
  localparam logic [10:0] V_MEMR   = 11'b0_01111_0_1_0_0_0;
  localparam logic [10:0] V_IOR    = 11'b0_11011_0_1_0_0_0;
  localparam logic [10:0] V_INTA   = 11'b0_11110_0_1_0_0_0;
  localparam logic [10:0] V_IOW    = 11'b0_11101_1_1_0_0_0;
  localparam logic [10:0] V_MEMW   = 11'b0_10111_1_1_0_0_0;
  localparam logic [10:0] V_DMA_RD = 11'b0_11111_0_0_0_0_0;
  localparam logic [10:0] V_T4_TO  = 11'b0_11111_1_0_0_1_1;
  localparam logic [10:0] V_IOW_T2  = {1'b0, 3'b111, WR_T2, 1'b1, 1'b1, 1'b1, 3'b000};
  localparam logic [10:0] V_MEMW_T2 = {1'b0, 1'b1, WR_T2, 2'b11, 1'b1, 1'b1, 1'b1, 3'b000};

  typedef struct {
    logic [10:0] v;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [10:0] obs;
  assign obs = {address_latch_enable, memory_read_n, memory_write_n, io_read_n, io_write_n,
                interrupt_acknowledge_n, data_transmit_receive_n, data_enable,
                halt_detected, no_command_state, wait_timeout};

  // Monitor: compare every queued expectation at the falling edge
  always @(negedge clock) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
      end
    end
  end

  // One CPU clock: drive inputs, pulse the enable across one edge, queue the result
  task automatic step(input logic [2:0] st, input logic rdy, input logic [10:0] e, input string nm);
    @(posedge clock); #1;
    processor_status = st;
    processor_ready  = rdy;
    cpu_clock_en     = 1'b1;
    @(posedge clock); #1;
    cpu_clock_en = 1'b0;
    sb_q.push_back('{e, nm});
  endtask

  // Change AEN/reset between enables and queue the response for the next falling edge
  task automatic check_now(input logic aen_n, input logic rst, input logic [10:0] e, input string nm);
    @(negedge clock); #1;
    address_enable_n = aen_n;
    reset            = rst;
    sb_q.push_back('{e, nm});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a live read status, then release: no cycle until passive is seen
    check_now(1'b1, 1'b1, V_IDLE, "reset_values");
    check_now(1'b1, 1'b0, V_IDLE, "reset_release");
    step(3'b101, 1'b1, V_IDLE, "idle_unarmed_a");
    step(3'b101, 1'b1, V_IDLE, "idle_unarmed_b");
    step(3'b111, 1'b1, V_IDLE, "idle_passive");

    // Memory read, zero wait states
    step(3'b101, 1'b1, V_T1_RD, "mr_t1");
    step(3'b111, 1'b1, V_MEMR,  "mr_t2");
    step(3'b111, 1'b0, V_MEMR,  "mr_t3");
    step(3'b111, 1'b1, V_IDLE,  "mr_t4");
    step(3'b111, 1'b1, V_IDLE,  "mr_idle");

    // IO write with two wait states
    step(3'b010, 1'b1, V_T1_WR,  "iow_t1");
    step(3'b111, 1'b1, V_IOW_T2, "iow_t2");
    step(3'b111, 1'b1, V_IOW,    "iow_t3");
    step(3'b111, 1'b0, V_IOW,    "iow_tw1");
    step(3'b111, 1'b0, V_IOW,    "iow_tw2");
    step(3'b111, 1'b1, V_IDLE,   "iow_t4");
    step(3'b111, 1'b1, V_IDLE,   "iow_idle");

    // Back-to-back INTA
    step(3'b000, 1'b1, V_T1_RD, "inta1_t1");
    step(3'b111, 1'b1, V_INTA,  "inta1_t2");
    step(3'b111, 1'b1, V_INTA,  "inta1_t3");
    step(3'b111, 1'b1, V_IDLE,  "inta1_t4");
    step(3'b000, 1'b1, V_T1_RD, "inta2_t1");
    step(3'b111, 1'b1, V_INTA,  "inta2_t2");
    step(3'b111, 1'b1, V_INTA,  "inta2_t3");
    step(3'b111, 1'b1, V_IDLE,  "inta2_t4");
    step(3'b111, 1'b1, V_IDLE,  "inta_idle");

    // DMA override during a memory read
    step(3'b101, 1'b1, V_T1_RD, "dma_t1");
    step(3'b111, 1'b1, V_MEMR,  "dma_t2");
    check_now(1'b0, 1'b0, V_DMA_RD, "dma_assert_t2");
    step(3'b111, 1'b1, V_DMA_RD, "dma_t3");
    step(3'b111, 1'b0, V_DMA_RD, "dma_tw");
    check_now(1'b1, 1'b0, V_MEMR, "dma_release_tw");
    step(3'b111, 1'b1, V_IDLE, "dma_t4");
    step(3'b111, 1'b1, V_IDLE, "dma_idle");

    // Wait timeout: exactly four TW states, then forced T4
    step(3'b110, 1'b0, V_T1_WR,   "to_t1");
    step(3'b111, 1'b0, V_MEMW_T2, "to_t2");
    step(3'b111, 1'b0, V_MEMW,    "to_t3");
    for (int i = 1; i <= 4; i++) step(3'b111, 1'b0, V_MEMW, $sformatf("to_tw%0d", i));
    step(3'b111, 1'b0, V_T4_TO, "to_t4");
    step(3'b111, 1'b0, V_T4_TO, "to_idle_sticky");
    step(3'b001, 1'b1, V_T1_RD, "to_clear_t1");
    step(3'b111, 1'b1, V_IOR,   "ior_t2");
    step(3'b111, 1'b1, V_IOR,   "ior_t3");
    step(3'b111, 1'b1, V_IDLE,  "ior_t4");
    step(3'b111, 1'b1, V_IDLE,  "ior_idle");

    // Halt: single-clock pulse, no strobes
    step(3'b011, 1'b1, V_HALT, "halt_pulse");
    check_now(1'b1, 1'b0, V_IDLE, "halt_cleared");
    step(3'b111, 1'b1, V_IDLE, "halt_idle");

    // Reset in the middle of a read cycle
    step(3'b101, 1'b1, V_T1_RD, "rst_t1");
    step(3'b111, 1'b1, V_MEMR,  "rst_t2");
    check_now(1'b1, 1'b1, V_IDLE, "rst_mid");
    check_now(1'b1, 1'b0, V_IDLE, "rst_mid_release");
    step(3'b101, 1'b1, V_IDLE,  "rst_unarmed");
    step(3'b111, 1'b1, V_IDLE,  "rst_passive");
    step(3'b101, 1'b1, V_T1_RD, "rst_restart_t1");

    repeat (4) @(posedge clock);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xt_bus_controller.md
Name: xt_bus_controller

Overview:
- 8288-style bus command generator between the 8088 CPU core and the chipset bus arbiter.
- Decodes the processor status lines S2..S0 into an 8088 T-state sequence. Produces ALE, the memory, I/O and INTA command strobes, DT/R and DEN.
- Inserts wait states while ready is low.
- Releases all command strobes when DMA owns the bus (AEN asserted).

Parameters:
- CMD_DELAY_T, default 1: number of CPU clocks after T1 before read/INTA strobes assert (1 = assert at T2, the 8288 standard).
- WAIT_TIMEOUT, default 1023: maximum consecutive Tw states before the forced-ready abort; 0 disables the abort.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- cpu_clock_en  input  1  one-cycle pulse marking each CPU clock edge; all T-state advances occur only on it
- processor_status  input  3  S2..S0 from the CPU; 3'b111 = passive
- processor_ready  input  1  synchronised READY, sampled at the end of T3/Tw
- address_enable_n  input  1  0 = DMA owns the bus
- address_latch_enable  output  1  ALE
- memory_read_n  output  1  MEMR command, active low
- memory_write_n  output  1  MEMW command, active low
- io_read_n  output  1  IOR command, active low
- io_write_n  output  1  IOW command, active low
- interrupt_acknowledge_n  output  1  INTA command, active low
- data_transmit_receive_n  output  1  DT/R; 0 = CPU receives
- data_enable  output  1  DEN
- halt_detected  output  1  one-clock pulse on a halt status
- no_command_state  output  1  1 while idle or passive
- wait_timeout  output  1  sticky flag; cleared on the next T1

Behaviour:
- Reset values:
  - all command strobes = 1; address_latch_enable = 0; data_enable = 0
  - data_transmit_receive_n = 1; halt_detected = 0; no_command_state = 1; wait_timeout = 0
  - state = IDLE
- Status decode (S2..S0):
  - 000 INTA; 001 IO read; 010 IO write; 011 halt
  - 100 code fetch; 101 mem read; 110 mem write; 111 passive
  - Code fetch is treated as mem read.
- States: IDLE, T1, T2, T3, TW, T4. All transitions occur on a clock where cpu_clock_en=1.
- IDLE:
  - Status != 111 and != 011 -> T1; latch the status into cycle_type.
  - Status 011 -> halt_detected pulses for 1 clock; stay in IDLE.
- T1:
  - address_latch_enable=1 for the whole T1 (from the enable that enters T1 until the next enable).
  - data_transmit_receive_n=0 for read, INTA and fetch cycles; 1 for writes.
  - Next state -> T2.
- T2:
  - Read, fetch and INTA strobes assert; data_enable=1.
  - For writes, data_enable asserts at T2 but the write strobe waits for T3 (advanced write is optional, see below).
  - Next state -> T3.
- T3:
  - Write strobes assert.
  - On the enable that ends T3: processor_ready=1 -> T4; else -> TW.
- TW:
  - All strobes are held.
  - processor_ready=1 at an enable -> T4.
  - A wait counter increments per TW. On reaching WAIT_TIMEOUT: set wait_timeout and force -> T4.
- T4:
  - All strobes deassert on entry; data_enable=0; data_transmit_receive_n returns to 1.
  - At the next enable: status already non-passive -> T1 (back-to-back cycle); else -> IDLE.
- no_command_state = 1 in IDLE, T1 and T4; otherwise 0.
- address_enable_n=0 (DMA owns the bus):
  - All command outputs are forced to 1 and data_enable=0 combinationally.
  - The state machine keeps running.
  - Deasserting address_enable_n mid-cycle restores the strobes for the current state on the same clock.
- Only one command strobe is ever low at a time.
- Reset mid-cycle: immediately returns to reset values; no partial strobes.
- Status changing during T2..TW is ignored; cycle_type is held until T4.
- processor_ready already 1 at T3: zero wait states, 4 CPU clocks total.

Optional Feature:
- Macro XT_BUS_ADVANCED_WRITE_EN.
- Defined: memory_write_n and io_write_n assert at T2 together with data_enable (8288 AMWC/AIOWC behaviour).
- Undefined: write strobes assert at T3 (normal write timing).
- Read and INTA timing is unaffected either way.

Decomposition:
- Package xt_bus_pkg holds:
  - typedef enum for the bus states (IDLE, T1, T2, T3, TW, T4)
  - typedef enum for the cycle type (INTA, IOR, IOW, HALT, FETCH, MEMR, MEMW, PASSIVE)
  - localparam STATUS_PASSIVE = 3'b111 and STATUS_HALT = 3'b011
- One natural sub-module: xt_bus_status_decode.
  - Combinational: status -> cycle_type, is_read, is_write.
  - Reused by the bus arbiter.

Test Plan:
- Reset: assert reset with status=101 -> all strobes 1, ALE 0; after release, IDLE until passive->101 is seen.
- Mem read, ready=1: status 101 at enable n -> ALE high for enable n..n+1; memory_read_n low from enable n+1 to n+3; T4 at n+3; 4 CPU clocks total.
- IO write with 2 wait states (ready low for 2 enables after T3) -> io_write_n low from T3 for 3 CPU clocks; data_transmit_receive_n=1 throughout; with XT_BUS_ADVANCED_WRITE_EN, low from T2 for 4 clocks.
- INTA back-to-back: two 000 cycles -> two separate interrupt_acknowledge_n pulses; ALE re-asserts on the second T1 with no IDLE in between.
- DMA override: address_enable_n=0 during T2 of a mem read -> memory_read_n=1 and data_enable=0 on the same clock; releasing it in TW restores memory_read_n=0.
- Timeout: WAIT_TIMEOUT=4, ready held 0 -> exactly 4 TW states, wait_timeout=1, T4 entered; flag clears at the next T1. Halt status 011 -> halt_detected pulses for 1 clock and no strobes assert.
